fft_agu: RTL and testbench
==========================

FFT_AGU -- requirements
Module: fft_agu

Interface
REQ-001 SHALL have parameter N_LOG2, default 5, the log2 of the FFT length (N = 2^N_LOG2 = 32 points, N_LOG2 stages, N/2 = 16 butterflies per stage).
REQ-002 SHALL have parameter BF_LAT, default 3, the butterfly datapath latency in cycles from read issue to write-back (legal range 1..8).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port n_rst  input  1  reset; one clock; reset is asynchronous and active-high.
REQ-005 SHALL have port start  input  1  single-cycle request to run one full in-place FFT pass.
REQ-006 SHALL have port rd_en  output  1  butterfly operand read strobe to sample RAM.
REQ-007 SHALL have ports rd_addr_a, rd_addr_b  output  N_LOG2 each  butterfly upper/lower operand read addresses.
REQ-008 SHALL have port tw_idx  output  N_LOG2-1  twiddle ROM index, aligned with rd_en.
REQ-009 SHALL have port wr_en  output  1  butterfly result write strobe.
REQ-010 SHALL have ports wr_addr_a, wr_addr_b  output  N_LOG2 each  result write addresses.
REQ-011 SHALL have port stage_idx  output  3  index of stage currently being issued (0..N_LOG2-1).
REQ-012 SHALL have port stage_done  output  1  one-cycle pulse on the final write of each stage.
REQ-013 SHALL have port busy  output  1  high from the cycle after start is accepted until done.
REQ-014 SHALL have port done  output  1  one-cycle pulse when the entire FFT pass completes.

Function
REQ-015 SHALL implement states IDLE, ISSUE, DRAIN, DONE.
REQ-016 IDLE: start=1 at an edge SHALL move to ISSUE with stage s=0, butterfly j=0; start SHALL be ignored in any state other than IDLE.
REQ-017 ISSUE: rd_en=1 every cycle; j increments 0..N/2-1; after j=N/2-1 SHALL move to DRAIN.
REQ-018 Address rule for stage s, butterfly j: span=2^s, grp=j>>s, pos=j&(span-1); rd_addr_a=(grp<<(s+1))|pos; rd_addr_b=rd_addr_a+span; tw_idx=pos<<(N_LOG2-1-s); all unsigned, no overflow possible by construction.
REQ-019 wr_en, wr_addr_a, wr_addr_b SHALL equal rd_en, rd_addr_a, rd_addr_b delayed by exactly BF_LAT cycles (shift register, not recomputed).
REQ-020 DRAIN: SHALL last exactly BF_LAT cycles with rd_en=0, so no read of stage s+1 precedes the final write of stage s.
REQ-021 DRAIN end: if s<N_LOG2-1, s increments and state returns to ISSUE with j=0; else state moves to DONE.
REQ-022 stage_done SHALL be high exactly in the cycle carrying the last wr_en of each stage (N_LOG2 pulses per pass).
REQ-023 DONE: done=1 and busy=0 for one cycle, then IDLE; start in DONE cycle is ignored.
REQ-024 Per-stage period SHALL be N/2+BF_LAT cycles; with defaults start at edge k gives rd_en in cycles k+1..k+16, wr_en k+4..k+19, next stage rd_en from k+20.
REQ-025 stage_idx SHALL hold last value through DRAIN and return to 0 in IDLE.

Reset
REQ-026 n_rst=1 SHALL immediately force IDLE, s=0, j=0, clear the delay line, and drive rd_en, wr_en, stage_done, busy, done, all addresses, tw_idx and stage_idx to 0.
REQ-027 Reset asserted mid-pass SHALL abort with no further wr_en; a new start after reset release SHALL begin a fresh pass from stage 0.

Verification
REQ-028 Defaults, start at edge k -> cycle k+1: rd_addr_a=0, rd_addr_b=1, tw_idx=0; wr_en first high at k+4 with wr_addr_a=0, wr_addr_b=1.
REQ-029 Stage 2, j=5 -> rd_addr_a=9, rd_addr_b=13, tw_idx=4; stage 4, j=15 -> rd_addr_a=15, rd_addr_b=31, tw_idx=15.
REQ-030 Full pass, defaults -> exactly 80 rd_en and 80 wr_en cycles, 5 stage_done pulses (k+19, k+38, k+57, k+76, k+95), done at k+96, busy low from k+96.
REQ-031 Scoreboard: every address 0..31 written exactly once per stage; no stage-(s+1) read before final stage-s write.
REQ-032 start pulsed at k+10 during a pass -> no effect, timing identical to REQ-030.
REQ-033 n_rst pulsed at k+30 -> all outputs 0 same cycle, no wr_en thereafter; start after release -> pass matches REQ-028 relative to new start.

Source files
------------

// File: rtl/fft_agu.sv
// Address generation unit for an in-place radix-2 decimation-in-time FFT.
// Issues N/2 butterfly operand reads per stage, then drains the butterfly
// pipeline for BF_LAT cycles so a stage's final write lands before the next
// stage's first read. Write addresses come from a shift register copy of the
// read addresses rather than being recomputed.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for start; all outputs low
// ISSUE | one butterfly read per cycle, j = 0..N/2-1 of stage s
// DRAIN | BF_LAT cycles with no reads while the pipeline empties
// DONE  | one-cycle done pulse, busy low, then back to IDLE
module fft_agu #(
    parameter int N_LOG2 = 5,
    parameter int BF_LAT = 3
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              start,
    output logic              rd_en,
    output logic [N_LOG2-1:0] rd_addr_a,
    output logic [N_LOG2-1:0] rd_addr_b,
    output logic [N_LOG2-2:0] tw_idx,
    output logic              wr_en,
    output logic [N_LOG2-1:0] wr_addr_a,
    output logic [N_LOG2-1:0] wr_addr_b,
    output logic [2:0]        stage_idx,
    output logic              stage_done,
    output logic              busy,
    output logic              done
);

    localparam int AW = N_LOG2;
    localparam int JW = N_LOG2 - 1;
    localparam logic [JW-1:0] LAST_J     = '1;
    localparam logic [2:0]    LAST_S     = 3'(N_LOG2 - 1);
    localparam logic [2:0]    JW3        = 3'(JW);
    localparam logic [3:0]    DRAIN_INIT = 4'(BF_LAT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        state, state_nxt;
    logic [JW-1:0] j, j_nxt;
    logic [2:0]    s, s_nxt;
    logic [3:0]    drain_cnt, drain_cnt_nxt;

    logic          issue;
    logic          last_issue;
    logic [AW-1:0] j_ext;
    logic [AW-1:0] span;
    logic [AW-1:0] low_mask;
    logic [AW-1:0] pos;
    logic [AW-1:0] addr_a_raw;
    logic [JW-1:0] tw_raw;

    logic          dl_en   [BF_LAT];
    logic          dl_last [BF_LAT];
    logic [AW-1:0] dl_a    [BF_LAT];
    logic [AW-1:0] dl_b    [BF_LAT];

    // State, butterfly index, stage index and drain timer registers.
    always_ff @(posedge clk or posedge n_rst) begin
        if (n_rst) begin
            state     <= IDLE;
            j         <= '0;
            s         <= '0;
            drain_cnt <= '0;
        end else begin
            state     <= state_nxt;
            j         <= j_nxt;
            s         <= s_nxt;
            drain_cnt <= drain_cnt_nxt;
        end
    end

    // Next-state logic: walk j through a stage, drain, then advance s or finish.
    always_comb begin
        state_nxt     = state;
        j_nxt         = j;
        s_nxt         = s;
        drain_cnt_nxt = drain_cnt;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = ISSUE;
                    j_nxt     = '0;
                    s_nxt     = '0;
                end
            end
            ISSUE: begin
                if (j == LAST_J) begin
                    state_nxt     = DRAIN;
                    drain_cnt_nxt = DRAIN_INIT;
                end else begin
                    j_nxt = j + JW'(1);
                end
            end
            DRAIN: begin
                if (drain_cnt == 4'd0) begin
                    if (s == LAST_S) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt = ISSUE;
                        s_nxt     = s + 3'd1;
                        j_nxt     = '0;
                    end
                end else begin
                    drain_cnt_nxt = drain_cnt - 4'd1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
                s_nxt     = '0;
                j_nxt     = '0;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Operand addresses: insert a zero at bit s of j for the upper operand,
    // the lower operand sets that bit; twiddle is pos scaled to the ROM range.
    always_comb begin
        j_ext      = {1'b0, j};
        span       = AW'(1) << s;
        low_mask   = span - AW'(1);
        pos        = j_ext & low_mask;
        addr_a_raw = ((j_ext & ~low_mask) << 1) | pos;
        tw_raw     = JW'(pos) << (JW3 - s);
    end

    assign issue      = (state == ISSUE);
    assign last_issue = issue && (j == LAST_J);

    assign rd_en     = issue;
    assign rd_addr_a = issue ? addr_a_raw : '0;
    assign rd_addr_b = issue ? (addr_a_raw | span) : '0;
    assign tw_idx    = issue ? tw_raw : '0;

    // Read-to-write delay line; the last-butterfly flag rides along so the
    // stage_done pulse lines up with the final write of each stage.
    always_ff @(posedge clk or posedge n_rst) begin
        if (n_rst) begin
            for (int i = 0; i < BF_LAT; i++) begin
                dl_en[i]   <= 1'b0;
                dl_last[i] <= 1'b0;
                dl_a[i]    <= '0;
                dl_b[i]    <= '0;
            end
        end else begin
            dl_en[0]   <= issue;
            dl_last[0] <= last_issue;
            dl_a[0]    <= rd_addr_a;
            dl_b[0]    <= rd_addr_b;
            for (int i = 1; i < BF_LAT; i++) begin
                dl_en[i]   <= dl_en[i-1];
                dl_last[i] <= dl_last[i-1];
                dl_a[i]    <= dl_a[i-1];
                dl_b[i]    <= dl_b[i-1];
            end
        end
    end

    assign wr_en      = dl_en[BF_LAT-1];
    assign wr_addr_a  = dl_a[BF_LAT-1];
    assign wr_addr_b  = dl_b[BF_LAT-1];
    assign stage_done = dl_en[BF_LAT-1] & dl_last[BF_LAT-1];

    assign stage_idx = s;
    assign busy      = (state == ISSUE) || (state == DRAIN);
    assign done      = (state == DONE);

endmodule

// File: tb/tb_fft_agu.sv
// Self-checking bench for fft_agu: per-cycle comparison of every output
// against a schedule computed from the FFT stage arithmetic, plus a
// per-stage write scoreboard, start-ignore and mid-pass reset scenarios.
module tb_fft_agu;

    localparam int N_LOG2   = 5;
    localparam int BF_LAT   = 3;
    localparam int N        = 1 << N_LOG2;
    localparam int HALF     = N / 2;
    localparam int P        = HALF + BF_LAT;
    localparam int NS       = N_LOG2;
    localparam int PASS_LEN = NS * P;

    logic              clk;
    logic              n_rst;
    logic              start;
    logic              rd_en;
    logic [N_LOG2-1:0] rd_addr_a;
    logic [N_LOG2-1:0] rd_addr_b;
    logic [N_LOG2-2:0] tw_idx;
    logic              wr_en;
    logic [N_LOG2-1:0] wr_addr_a;
    logic [N_LOG2-1:0] wr_addr_b;
    logic [2:0]        stage_idx;
    logic              stage_done;
    logic              busy;
    logic              done;

    int n_checks = 0;
    int n_pass   = 0;

    fft_agu #(.N_LOG2(N_LOG2), .BF_LAT(BF_LAT)) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .start      (start),
        .rd_en      (rd_en),
        .rd_addr_a  (rd_addr_a),
        .rd_addr_b  (rd_addr_b),
        .tw_idx     (tw_idx),
        .wr_en      (wr_en),
        .wr_addr_a  (wr_addr_a),
        .wr_addr_b  (wr_addr_b),
        .stage_idx  (stage_idx),
        .stage_done (stage_done),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: butterfly j of stage s pairs element a with a+span,
    // where groups of 2*span elements hold span butterflies each.
    function automatic int m_addr_a(input int s, input int j);
        int span;
        span = 1 << s;
        return (j / span) * (2 * span) + (j % span);
    endfunction

    function automatic int m_tw(input int s, input int j);
        int span;
        span = 1 << s;
        return (j % span) * (HALF / span);
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        logic [63:0] all_out;
        n_rst = 1'b1;
        start = 1'b0;
        #2;
        all_out = 64'({rd_en, rd_addr_a, rd_addr_b, tw_idx, wr_en, wr_addr_a,
                       wr_addr_b, stage_idx, stage_done, busy, done});
        n_checks++;
        if (all_out !== 64'd0) $display("FAIL reset_outputs got=%h exp=0", all_out);
        else n_pass++;
        tick;
        tick;
        n_rst = 1'b0;
        tick;
        all_out = 64'({rd_en, rd_addr_a, rd_addr_b, tw_idx, wr_en, wr_addr_a,
                       wr_addr_b, stage_idx, stage_done, busy, done});
        n_checks++;
        if (all_out !== 64'd0) $display("FAIL idle_outputs got=%h exp=0", all_out);
        else n_pass++;
    endtask

    // One complete pass checked cycle by cycle; optionally pulses start while
    // busy and during the DONE cycle, all of which must be ignored.
    task automatic test_full_pass(input bit inject_starts, input string tag);
        int wcnt [NS][N];
        int rd_total, wr_total, sd_total, done_rel, bad, t, t2, es, ej;
        logic              e_rd, e_wr, e_sd, e_busy, e_done;
        logic [N_LOG2-1:0] e_a, e_b, e_wa, e_wb;
        logic [N_LOG2-2:0] e_tw;
        logic [2:0]        e_stage;
        for (int s = 0; s < NS; s++)
            for (int a = 0; a < N; a++) wcnt[s][a] = 0;
        rd_total = 0; wr_total = 0; sd_total = 0; done_rel = -1;
        repeat ($urandom_range(0, 3)) tick;
        start = 1'b1;
        tick;
        start = 1'b0;
        for (int rel = 1; rel <= PASS_LEN + 3; rel++) begin
            t  = rel - 1;
            t2 = rel - 1 - BF_LAT;
            e_rd = 1'b0; e_a = '0; e_b = '0; e_tw = '0; e_stage = '0;
            if (t < PASS_LEN) begin
                es = t / P;
                e_stage = 3'(es);
                if ((t % P) < HALF) begin
                    ej   = t % P;
                    e_rd = 1'b1;
                    e_a  = N_LOG2'(m_addr_a(es, ej));
                    e_b  = N_LOG2'(m_addr_a(es, ej) + (1 << es));
                    e_tw = (N_LOG2-1)'(m_tw(es, ej));
                end
            end
            e_wr = 1'b0; e_sd = 1'b0; e_wa = '0; e_wb = '0;
            if (t2 >= 0 && t2 < PASS_LEN && (t2 % P) < HALF) begin
                es   = t2 / P;
                ej   = t2 % P;
                e_wr = 1'b1;
                e_sd = (ej == HALF - 1);
                e_wa = N_LOG2'(m_addr_a(es, ej));
                e_wb = N_LOG2'(m_addr_a(es, ej) + (1 << es));
            end
            e_busy = (rel >= 1 && rel <= PASS_LEN);
            e_done = (rel == PASS_LEN + 1);

            n_checks++;
            if (rd_en !== e_rd) $display("FAIL %s rd_en rel=%0d got=%b exp=%b", tag, rel, rd_en, e_rd);
            else n_pass++;
            if (e_rd) begin
                n_checks++;
                if ({rd_addr_a, rd_addr_b, tw_idx} !== {e_a, e_b, e_tw})
                    $display("FAIL %s rd_addr rel=%0d got=%0d/%0d/%0d exp=%0d/%0d/%0d",
                             tag, rel, rd_addr_a, rd_addr_b, tw_idx, e_a, e_b, e_tw);
                else n_pass++;
            end
            if (rel != PASS_LEN + 1) begin
                n_checks++;
                if (stage_idx !== e_stage) $display("FAIL %s stage_idx rel=%0d got=%0d exp=%0d", tag, rel, stage_idx, e_stage);
                else n_pass++;
            end
            n_checks++;
            if (wr_en !== e_wr) $display("FAIL %s wr_en rel=%0d got=%b exp=%b", tag, rel, wr_en, e_wr);
            else n_pass++;
            if (e_wr) begin
                n_checks++;
                if ({wr_addr_a, wr_addr_b} !== {e_wa, e_wb})
                    $display("FAIL %s wr_addr rel=%0d got=%0d/%0d exp=%0d/%0d", tag, rel, wr_addr_a, wr_addr_b, e_wa, e_wb);
                else n_pass++;
            end
            n_checks++;
            if ({stage_done, busy, done} !== {e_sd, e_busy, e_done})
                $display("FAIL %s sd_busy_done rel=%0d got=%b%b%b exp=%b%b%b",
                         tag, rel, stage_done, busy, done, e_sd, e_busy, e_done);
            else n_pass++;

            if (rel == 1) begin
                n_checks++;
                if ({rd_addr_a, rd_addr_b, tw_idx} !== {5'd0, 5'd1, 4'd0})
                    $display("FAIL %s first_read got=%0d/%0d/%0d exp=0/1/0", tag, rd_addr_a, rd_addr_b, tw_idx);
                else n_pass++;
            end
            if (rel == 1 + 2 * P + 5) begin
                n_checks++;
                if ({rd_addr_a, rd_addr_b, tw_idx} !== {5'd9, 5'd13, 4'd4})
                    $display("FAIL %s s2_j5 got=%0d/%0d/%0d exp=9/13/4", tag, rd_addr_a, rd_addr_b, tw_idx);
                else n_pass++;
            end
            if (rel == 1 + 4 * P + 15) begin
                n_checks++;
                if ({rd_addr_a, rd_addr_b, tw_idx} !== {5'd15, 5'd31, 4'd15})
                    $display("FAIL %s s4_j15 got=%0d/%0d/%0d exp=15/31/15", tag, rd_addr_a, rd_addr_b, tw_idx);
                else n_pass++;
            end

            if (rd_en === 1'b1) begin
                if (rd_total > 0 && (rd_total % HALF) == 0) begin
                    n_checks++;
                    if (sd_total < rd_total / HALF)
                        $display("FAIL %s read_before_write rel=%0d stages_done=%0d need=%0d", tag, rel, sd_total, rd_total / HALF);
                    else n_pass++;
                end
                rd_total++;
            end
            if (wr_en === 1'b1) begin
                wr_total++;
                if (sd_total < NS) begin
                    wcnt[sd_total][wr_addr_a]++;
                    wcnt[sd_total][wr_addr_b]++;
                end
            end
            if (stage_done === 1'b1) sd_total++;
            if (done === 1'b1 && done_rel < 0) done_rel = rel;

            if (inject_starts && (rel == 10 || rel == PASS_LEN + 1 ||
                (rel < PASS_LEN && $urandom_range(0, 7) == 0)))
                start = 1'b1;
            else
                start = 1'b0;
            tick;
        end
        start = 1'b0;

        n_checks++;
        if (rd_total != NS * HALF) $display("FAIL %s rd_count got=%0d exp=%0d", tag, rd_total, NS * HALF);
        else n_pass++;
        n_checks++;
        if (wr_total != NS * HALF) $display("FAIL %s wr_count got=%0d exp=%0d", tag, wr_total, NS * HALF);
        else n_pass++;
        n_checks++;
        if (sd_total != NS) $display("FAIL %s stage_done_count got=%0d exp=%0d", tag, sd_total, NS);
        else n_pass++;
        n_checks++;
        if (done_rel != PASS_LEN + 1) $display("FAIL %s done_cycle got=%0d exp=%0d", tag, done_rel, PASS_LEN + 1);
        else n_pass++;
        for (int s = 0; s < NS; s++) begin
            bad = 0;
            for (int a = 0; a < N; a++) if (wcnt[s][a] != 1) bad++;
            n_checks++;
            if (bad != 0) $display("FAIL %s write_once stage=%0d bad_addrs=%0d exp=0", tag, s, bad);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid_pass;
        logic [63:0] all_out;
        int          stray;
        start = 1'b1;
        tick;
        start = 1'b0;
        repeat (29) tick;
        n_checks++;
        if (wr_en !== 1'b1) $display("FAIL mid_reset pre_wr_en got=%b exp=1", wr_en);
        else n_pass++;
        #2;
        n_rst = 1'b1;
        #1;
        all_out = 64'({rd_en, rd_addr_a, rd_addr_b, tw_idx, wr_en, wr_addr_a,
                       wr_addr_b, stage_idx, stage_done, busy, done});
        n_checks++;
        if (all_out !== 64'd0) $display("FAIL mid_reset outputs got=%h exp=0", all_out);
        else n_pass++;
        tick;
        tick;
        n_rst = 1'b0;
        stray = 0;
        for (int c = 0; c < 12; c++) begin
            tick;
            if (wr_en !== 1'b0 || busy !== 1'b0 || rd_en !== 1'b0) stray++;
        end
        n_checks++;
        if (stray != 0) $display("FAIL mid_reset stray_activity got=%0d exp=0", stray);
        else n_pass++;
        test_full_pass(1'b0, "after_reset");
    endtask

    task automatic test_back_to_back;
        test_full_pass(1'b1, "b2b_first");
        test_full_pass(1'b0, "b2b_second");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", n_checks);
        $fatal(1, "timeout");
    end

    initial begin
        n_rst = 1'b1;
        start = 1'b0;
        test_reset;
        test_full_pass(1'b0, "plain");
        test_full_pass(1'b1, "start_during_pass");
        test_reset_mid_pass;
        test_back_to_back;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
